// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the MIPS-subset datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       overflow;
   logic       pc_write;
   logic       ir_write;
   logic       iord;
   logic       mem_wr;
   logic       reg_wr;
   logic [1:0] reg_dst_sel;
   logic [2:0] mem_to_reg_sel;
   logic [2:0] pc_src_sel;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       epc_write;
   logic       cause;
   logic [3:0] state_out;

   modport master (
      input  opcode, funct, zero, overflow,
      output pc_write, ir_write, iord, mem_wr, reg_wr, reg_dst_sel,
             mem_to_reg_sel, pc_src_sel, alu_src_a, alu_src_b, alu_op,
             epc_write, cause, state_out
   );

   modport slave (
      output opcode, funct, zero, overflow,
      input  pc_write, ir_write, iord, mem_wr, reg_wr, reg_dst_sel,
             mem_to_reg_sel, pc_src_sel, alu_src_a, alu_src_b, alu_op,
             epc_write, cause, state_out
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 32-bit MIPS-subset datapath: fetch, decode,
// execute, memory, writeback, plus overflow / invalid-opcode exceptions.
//
// state   | meaning
// RESET   | post-reset idle, one full cycle before the first fetch
// FETCH   | memory read of instruction, MEM_WAIT+1 cycles, PC+4
// DECODE  | instruction dispatch, branch target computed into ALUOut
// EXEC_R  | R-type ALU operation
// WB_R    | R-type / mfhi / mflo register writeback
// ADDR    | lw/sw effective address
// MEM_RD  | data read, MEM_WAIT+1 cycles
// WB_LW   | load writeback
// MEM_WR  | store strobe
// BRANCH  | beq/bne compare and conditional PC load
// JUMP    | j
// JAL     | jal, link to $31
// JR      | jr
// ADDI_EX | addi add
// ADDI_WB | addi writeback
// EXC     | EPC load and jump to exception vector
module multicycle_ctrl #(
   parameter int MEM_WAIT = 2
) (
   input logic              clk,
   input logic              reset_n,
   multicycle_ctrl_if.master bus
);

   localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
   localparam logic [CW-1:0] CNT_TC = CW'(MEM_WAIT);

   localparam logic [2:0] ALU_NONE = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;

   typedef enum logic [3:0] {
      S_RESET   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_EXEC_R  = 4'd3,
      S_WB_R    = 4'd4,
      S_ADDR    = 4'd5,
      S_MEM_RD  = 4'd6,
      S_WB_LW   = 4'd7,
      S_MEM_WR  = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_JAL     = 4'd11,
      S_JR      = 4'd12,
      S_ADDI_EX = 4'd13,
      S_ADDI_WB = 4'd14,
      S_EXC     = 4'd15
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL, OP_MFHI, OP_MFLO, OP_JR,
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_BAD
   } op_t;

   state_t        r_state;
   state_t        w_next;
   op_t           r_op;
   op_t           w_dec_op;
   logic [CW-1:0] r_cnt;
   logic          r_boot;
   logic          r_cause;
   logic          w_next_cause;
   logic          w_tc;

   logic       w_pc_write;
   logic       w_ir_write;
   logic       w_iord;
   logic       w_mem_wr;
   logic       w_reg_wr;
   logic [1:0] w_reg_dst_sel;
   logic [2:0] w_mem_to_reg_sel;
   logic [2:0] w_pc_src_sel;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [2:0] w_alu_op;
   logic       w_epc_write;
   logic       w_cause;

   assign w_tc = (r_cnt == CNT_TC);

   always_comb begin
      w_dec_op = OP_BAD;
      if (bus.opcode == 6'h00) begin
         case (bus.funct)
            6'h20:   w_dec_op = OP_ADD;
            6'h22:   w_dec_op = OP_SUB;
            6'h24:   w_dec_op = OP_AND;
            6'h2A:   w_dec_op = OP_SLT;
            6'h00:   w_dec_op = OP_SLL;
            6'h10:   w_dec_op = OP_MFHI;
            6'h12:   w_dec_op = OP_MFLO;
            6'h08:   w_dec_op = OP_JR;
            default: w_dec_op = OP_BAD;
         endcase
      end else begin
         case (bus.opcode)
            6'h23:   w_dec_op = OP_LW;
            6'h2B:   w_dec_op = OP_SW;
            6'h04:   w_dec_op = OP_BEQ;
            6'h05:   w_dec_op = OP_BNE;
            6'h02:   w_dec_op = OP_J;
            6'h03:   w_dec_op = OP_JAL;
            6'h08:   w_dec_op = OP_ADDI;
            default: w_dec_op = OP_BAD;
         endcase
      end
   end

   // The decoded class is latched in DECODE so later states do not depend on IR timing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_RESET;
         r_cnt   <= '0;
         r_boot  <= 1'b0;
         r_op    <= OP_BAD;
         r_cause <= 1'b0;
      end else begin
         r_state <= w_next;
         r_boot  <= 1'b1;
         if (r_state == S_DECODE)
            r_op <= w_dec_op;
         if (w_next != r_state)
            r_cnt <= '0;
         else if ((r_state == S_FETCH || r_state == S_MEM_RD) && !w_tc)
            r_cnt <= r_cnt + CW'(1);
         if (w_next == S_EXC && r_state != S_EXC)
            r_cause <= w_next_cause;
      end
   end

   always_comb begin
      w_next           = r_state;
      w_next_cause     = 1'b0;
      w_pc_write       = 1'b0;
      w_ir_write       = 1'b0;
      w_iord           = 1'b0;
      w_mem_wr         = 1'b0;
      w_reg_wr         = 1'b0;
      w_reg_dst_sel    = 2'b00;
      w_mem_to_reg_sel = 3'd0;
      w_pc_src_sel     = 3'd0;
      w_alu_src_a      = 1'b0;
      w_alu_src_b      = 2'b00;
      w_alu_op         = ALU_NONE;
      w_epc_write      = 1'b0;
      w_cause          = 1'b0;

      case (r_state)
         S_RESET: begin
            if (r_boot)
               w_next = S_FETCH;
         end
         S_FETCH: begin
            w_alu_src_b = 2'b01;
            w_alu_op    = ALU_ADD;
            if (w_tc) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_next     = S_DECODE;
            end
         end
         S_DECODE: begin
            w_alu_src_b = 2'b11;
            w_alu_op    = ALU_ADD;
            case (w_dec_op)
               OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL: w_next = S_EXEC_R;
               OP_MFHI, OP_MFLO:                       w_next = S_WB_R;
               OP_JR:                                  w_next = S_JR;
               OP_LW, OP_SW:                           w_next = S_ADDR;
               OP_BEQ, OP_BNE:                         w_next = S_BRANCH;
               OP_J:                                   w_next = S_JUMP;
               OP_JAL:                                 w_next = S_JAL;
               OP_ADDI:                                w_next = S_ADDI_EX;
               default: begin
                  w_next       = S_EXC;
                  w_next_cause = 1'b0;
               end
            endcase
         end
         S_EXEC_R: begin
            w_alu_src_a = 1'b1;
            case (r_op)
               OP_ADD:         w_alu_op = ALU_ADD;
               OP_SUB, OP_SLT: w_alu_op = ALU_SUB;
               OP_AND:         w_alu_op = ALU_AND;
               default:        w_alu_op = ALU_NONE;
            endcase
            // slt also subtracts, but its overflow is architecturally irrelevant.
            if ((r_op == OP_ADD || r_op == OP_SUB) && bus.overflow) begin
               w_next       = S_EXC;
               w_next_cause = 1'b1;
            end else begin
               w_next = S_WB_R;
            end
         end
         S_WB_R: begin
            w_reg_wr      = 1'b1;
            w_reg_dst_sel = 2'b01;
            case (r_op)
               OP_SLT:  w_mem_to_reg_sel = 3'd5;
               OP_SLL:  w_mem_to_reg_sel = 3'd4;
               OP_MFHI: w_mem_to_reg_sel = 3'd2;
               OP_MFLO: w_mem_to_reg_sel = 3'd3;
               default: w_mem_to_reg_sel = 3'd0;
            endcase
            w_next = S_FETCH;
         end
         S_ADDR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            w_alu_op    = ALU_ADD;
            w_next      = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            w_iord = 1'b1;
            if (w_tc)
               w_next = S_WB_LW;
         end
         S_WB_LW: begin
            w_reg_wr         = 1'b1;
            w_mem_to_reg_sel = 3'd1;
            w_next           = S_FETCH;
         end
         S_MEM_WR: begin
            w_iord   = 1'b1;
            w_mem_wr = 1'b1;
            w_next   = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_src_a  = 1'b1;
            w_alu_op     = ALU_SUB;
            w_pc_src_sel = 3'd1;
            w_pc_write   = ((r_op == OP_BEQ) && bus.zero) ||
                           ((r_op == OP_BNE) && !bus.zero);
            w_next       = S_FETCH;
         end
         S_JUMP: begin
            w_pc_write   = 1'b1;
            w_pc_src_sel = 3'd2;
            w_next       = S_FETCH;
         end
         S_JAL: begin
            w_pc_write       = 1'b1;
            w_pc_src_sel     = 3'd2;
            w_reg_wr         = 1'b1;
            w_reg_dst_sel    = 2'b10;
            w_mem_to_reg_sel = 3'd6;
            w_next           = S_FETCH;
         end
         S_JR: begin
            w_pc_write   = 1'b1;
            w_pc_src_sel = 3'd3;
            w_next       = S_FETCH;
         end
         S_ADDI_EX: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            w_alu_op    = ALU_ADD;
            if (bus.overflow) begin
               w_next       = S_EXC;
               w_next_cause = 1'b1;
            end else begin
               w_next = S_ADDI_WB;
            end
         end
         S_ADDI_WB: begin
            w_reg_wr = 1'b1;
            w_next   = S_FETCH;
         end
         S_EXC: begin
            w_epc_write  = 1'b1;
            w_pc_write   = 1'b1;
            w_pc_src_sel = 3'd4;
            w_cause      = r_cause;
            w_next       = S_FETCH;
         end
         default: w_next = S_RESET;
      endcase
   end

   assign bus.pc_write       = w_pc_write;
   assign bus.ir_write       = w_ir_write;
   assign bus.iord           = w_iord;
   assign bus.mem_wr         = w_mem_wr;
   assign bus.reg_wr         = w_reg_wr;
   assign bus.reg_dst_sel    = w_reg_dst_sel;
   assign bus.mem_to_reg_sel = w_mem_to_reg_sel;
   assign bus.pc_src_sel     = w_pc_src_sel;
   assign bus.alu_src_a      = w_alu_src_a;
   assign bus.alu_src_b      = w_alu_src_b;
   assign bus.alu_op         = w_alu_op;
   assign bus.epc_write      = w_epc_write;
   assign bus.cause          = w_cause;
   assign bus.state_out      = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class and checks
// state sequence, control words, fetch-to-fetch periods and reset abort.
module tb_multicycle_ctrl;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_err;
   int   cyc;
   int   t_fetch;
   int   t_prev;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.MEM_WAIT(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   logic [20:0] w_obs;
   assign w_obs = {bus.pc_write, bus.ir_write, bus.iord, bus.mem_wr, bus.reg_wr,
                   bus.reg_dst_sel, bus.mem_to_reg_sel, bus.pc_src_sel,
                   bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.epc_write, bus.cause};

   function automatic logic [20:0] ctl(
      input logic pcw, input logic irw, input logic iord, input logic memwr,
      input logic regwr, input logic [1:0] rdst, input logic [2:0] m2r,
      input logic [2:0] pcs, input logic asa, input logic [1:0] asb,
      input logic [2:0] aop, input logic epc, input logic cs);
      return {pcw, irw, iord, memwr, regwr, rdst, m2r, pcs, asa, asb, aop, epc, cs};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic st(input string tag, input logic [3:0] s, input logic [20:0] c);
      step();
      check({tag, "_state"}, {28'd0, bus.state_out}, {28'd0, s});
      check({tag, "_ctl"}, {11'd0, w_obs}, {11'd0, c});
   endtask

   // Enters FETCH from the last cycle of the previous instruction and ends in DECODE.
   task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn);
      st("fetch0", 4'd1, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,0,2'b01,3'd1,0,0));
      t_prev  = t_fetch;
      t_fetch = cyc;
      bus.opcode = op;
      bus.funct  = fn;
      st("fetch1", 4'd1, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,0,2'b01,3'd1,0,0));
      st("fetch2", 4'd1, ctl(1,1,0,0,0,2'b00,3'd0,3'd0,0,2'b01,3'd1,0,0));
      st("decode", 4'd2, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,0,2'b11,3'd1,0,0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_err = 0; cyc = 0; t_fetch = 0; t_prev = 0;
      reset_n = 1'b0;
      bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.overflow = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_state", {28'd0, bus.state_out}, 32'd0);
      check("rst_ctl", {11'd0, w_obs}, 32'd0);
      reset_n = 1'b1;
      st("boot", 4'd0, 21'd0);

      // add, no overflow
      do_fetch(6'h00, 6'h20);
      st("add_ex", 4'd3, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,1,2'b00,3'd1,0,0));
      st("add_wb", 4'd4, ctl(0,0,0,0,1,2'b01,3'd0,3'd0,0,2'b00,3'd0,0,0));

      // sub with overflow -> EXC cause 1
      do_fetch(6'h00, 6'h22);
      check("add_period", t_fetch - t_prev, 32'd6);
      bus.overflow = 1'b1;
      st("sub_ex", 4'd3, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,1,2'b00,3'd2,0,0));
      st("sub_exc", 4'd15, ctl(1,0,0,0,0,2'b00,3'd0,3'd4,0,2'b00,3'd0,1,1));

      // slt ignores overflow
      do_fetch(6'h00, 6'h2A);
      check("ovf_period", t_fetch - t_prev, 32'd6);
      st("slt_ex", 4'd3, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,1,2'b00,3'd2,0,0));
      st("slt_wb", 4'd4, ctl(0,0,0,0,1,2'b01,3'd5,3'd0,0,2'b00,3'd0,0,0));
      bus.overflow = 1'b0;

      // lw: three MEM_RD cycles
      do_fetch(6'h23, 6'h00);
      st("lw_addr", 4'd5, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,1,2'b10,3'd1,0,0));
      for (int i = 0; i < 3; i++)
         st("lw_rd", 4'd6, ctl(0,0,1,0,0,2'b00,3'd0,3'd0,0,2'b00,3'd0,0,0));
      st("lw_wb", 4'd7, ctl(0,0,0,0,1,2'b00,3'd1,3'd0,0,2'b00,3'd0,0,0));

      // sw
      do_fetch(6'h2B, 6'h00);
      check("lw_period", t_fetch - t_prev, 32'd9);
      st("sw_addr", 4'd5, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,1,2'b10,3'd1,0,0));
      st("sw_wr", 4'd8, ctl(0,0,1,1,0,2'b00,3'd0,3'd0,0,2'b00,3'd0,0,0));

      // beq taken
      do_fetch(6'h04, 6'h00);
      check("sw_period", t_fetch - t_prev, 32'd6);
      bus.zero = 1'b1;
      st("beq_t", 4'd9, ctl(1,0,0,0,0,2'b00,3'd0,3'd1,1,2'b00,3'd2,0,0));

      // beq not taken
      do_fetch(6'h04, 6'h00);
      bus.zero = 1'b0;
      st("beq_nt", 4'd9, ctl(0,0,0,0,0,2'b00,3'd0,3'd1,1,2'b00,3'd2,0,0));

      // bne taken
      do_fetch(6'h05, 6'h00);
      check("beq_period", t_fetch - t_prev, 32'd5);
      st("bne_t", 4'd9, ctl(1,0,0,0,0,2'b00,3'd0,3'd1,1,2'b00,3'd2,0,0));

      // jal
      do_fetch(6'h03, 6'h00);
      st("jal", 4'd11, ctl(1,0,0,0,1,2'b10,3'd6,3'd2,0,2'b00,3'd0,0,0));

      // mfhi
      do_fetch(6'h00, 6'h10);
      check("jal_period", t_fetch - t_prev, 32'd5);
      st("mfhi_wb", 4'd4, ctl(0,0,0,0,1,2'b01,3'd2,3'd0,0,2'b00,3'd0,0,0));

      // jr
      do_fetch(6'h00, 6'h08);
      st("jr", 4'd12, ctl(1,0,0,0,0,2'b00,3'd0,3'd3,0,2'b00,3'd0,0,0));

      // addi with overflow
      do_fetch(6'h08, 6'h00);
      bus.overflow = 1'b1;
      st("addi_ex", 4'd13, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,1,2'b10,3'd1,0,0));
      st("addi_exc", 4'd15, ctl(1,0,0,0,0,2'b00,3'd0,3'd4,0,2'b00,3'd0,1,1));
      bus.overflow = 1'b0;

      // invalid opcode
      do_fetch(6'h3F, 6'h00);
      st("bad_exc", 4'd15, ctl(1,0,0,0,0,2'b00,3'd0,3'd4,0,2'b00,3'd0,1,0));

      // reset during MEM_RD of a lw
      do_fetch(6'h23, 6'h00);
      check("bad_period", t_fetch - t_prev, 32'd5);
      st("lw2_addr", 4'd5, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,1,2'b10,3'd1,0,0));
      st("lw2_rd", 4'd6, ctl(0,0,1,0,0,2'b00,3'd0,3'd0,0,2'b00,3'd0,0,0));
      reset_n = 1'b0;
      #1;
      check("abort_state", {28'd0, bus.state_out}, 32'd0);
      check("abort_ctl", {11'd0, w_obs}, 32'd0);
      for (int i = 0; i < 3; i++)
         st("abort_hold", 4'd0, 21'd0);
      reset_n = 1'b1;
      #1;
      check("rel_state", {28'd0, bus.state_out}, 32'd0);
      st("rel_reset", 4'd0, 21'd0);
      st("rel_fetch", 4'd1, ctl(0,0,0,0,0,2'b00,3'd0,3'd0,0,2'b01,3'd1,0,0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Multicycle control FSM for the 32-bit MIPS-subset datapath.
- Sequences every instruction through fetch, decode, execute, memory and writeback.
- Drives the 3-bit selectors of the 7-input write-data mux and the PC-source mux, plus all datapath write enables.
- Handles the overflow and invalid-opcode exceptions.

## Interface

- MEM_WAIT, 2: memory read latency in cycles; data is valid MEM_WAIT cycles after the address is driven.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction [31:26] from the IR.
- funct  in  6  instruction [5:0] from the IR.
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU signed-overflow flag.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_wr  out  1  memory write strobe.
- reg_wr  out  1  register-file write enable.
- reg_dst_sel  out  2  write register: 00 = rt, 01 = rd, 10 = $31.
- mem_to_reg_sel  out  3  write-data mux select:
  - 0 ALUOut, 1 MDR, 2 HI, 3 LO, 4 shifter, 5 slt flag, 6 PC.
  - 7 is never driven.
- pc_src_sel  out  3  PC mux select: 0 ALU result, 1 ALUOut, 2 jump target, 3 reg A, 4 exception vector.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = reg A.
- alu_src_b  out  2  ALU B input: 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  3  ALU operation: 000 = none, 001 = ADD, 010 = SUB, 011 = AND.
- epc_write  out  1  EPC load enable.
- cause  out  1  exception cause, valid while epc_write=1: 0 = invalid opcode, 1 = overflow.
- state_out  out  4  current state encoding, for debug.

## Operation

**Output model**
- Moore outputs decoded from the state register.
- Exception: in BRANCH, pc_write also depends on opcode and zero.
- Every control not listed for a state is 0.

**State encoding**
- 0 RESET, 1 FETCH, 2 DECODE, 3 EXEC_R, 4 WB_R, 5 ADDR, 6 MEM_RD, 7 WB_LW.
- 8 MEM_WR, 9 BRANCH, 10 JUMP, 11 JAL, 12 JR, 13 ADDI_EX, 14 ADDI_WB, 15 EXC.

**State behaviour**
- RESET: all outputs 0. Next state is FETCH.
- FETCH: lasts MEM_WAIT+1 cycles, counted by an internal counter.
  - Every cycle: iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - Last cycle only: ir_write=1, pc_write=1, pc_src_sel=0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD. Dispatch on opcode/funct:
  - R-type add(20h)/sub(22h)/and(24h)/slt(2Ah)/sll(00h) → EXEC_R.
  - mfhi(10h)/mflo(12h) → WB_R.
  - jr(08h) → JR.
  - lw(23h)/sw(2Bh) → ADDR.
  - beq(04h)/bne(05h) → BRANCH.
  - j(02h) → JUMP.
  - jal(03h) → JAL.
  - addi(08h) → ADDI_EX.
  - Any other opcode, or an unlisted funct with opcode 0 → EXC with cause=0.
- EXEC_R: alu_src_a=1, alu_src_b=00.
  - alu_op: ADD for add, SUB for sub and slt, AND for and, none for sll.
  - add/sub with overflow=1 → EXC, cause=1. Otherwise → WB_R.
- WB_R: reg_wr=1, reg_dst_sel=01.
  - mem_to_reg_sel: 0 for add/sub/and, 5 for slt, 4 for sll, 2 for mfhi, 3 for mflo.
  - Next state is FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state: lw → MEM_RD, sw → MEM_WR.
- MEM_RD: MEM_WAIT+1 cycles with iord=1. Then WB_LW.
- WB_LW: reg_wr=1, reg_dst_sel=00, mem_to_reg_sel=1. Next state is FETCH.
- MEM_WR: iord=1, mem_wr=1 for one cycle. Next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src_sel=1.
  - pc_write = (beq & zero) | (bne & ~zero).
  - Next state is FETCH.
- JUMP: pc_write=1, pc_src_sel=2. Next state is FETCH.
- JAL: pc_write=1, pc_src_sel=2, reg_wr=1, reg_dst_sel=10, mem_to_reg_sel=6 (PC already incremented). Next state is FETCH.
- JR: pc_write=1, pc_src_sel=3. Next state is FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=ADD. overflow=1 → EXC with cause=1; otherwise → ADDI_WB.
- ADDI_WB: reg_wr=1, reg_dst_sel=00, mem_to_reg_sel=0. Next state is FETCH.
- EXC: one cycle with epc_write=1, pc_write=1, pc_src_sel=4, cause held. Next state is FETCH.

**Flag sampling**
- The overflow flag is sampled only in EXEC_R (add/sub) and ADDI_EX; it is ignored in every other state.
- A faulting instruction never asserts reg_wr.

## Timing

**Reset**
- reset_n low → state=RESET and counter=0 immediately, regardless of clk.
- All outputs read 0 while reset_n is low.
- An instruction in flight is aborted: no further pc_write, reg_wr or mem_wr.
- First FETCH cycle is the second rising edge after reset_n rises (one RESET cycle in between).

**Cycle counts per instruction, FETCH to FETCH, MEM_WAIT=2**
- add/sub/and/slt/sll/addi: 6.
- mfhi/mflo, j, jal, jr, beq/bne: 5.
- sw: 6.
- lw: 9.
- exception: 5 for invalid opcode, 6 for overflow.

**Counter**
- The FETCH/MEM_RD counter clears on every state entry.
- It never wraps within a state.

## Test plan

- Reset mid-operation: hold reset_n=0 for 3 cycles during MEM_RD → state_out=0 and all outputs 0 immediately; after release, state_out goes 0 then 1; no reg_wr is seen for the aborted lw.
- add without overflow (opcode 0, funct 20h, overflow=0) → states 1,1,1,2,3,4,1; in state 4, reg_wr=1, reg_dst_sel=01, mem_to_reg_sel=0.
- lw (23h), MEM_WAIT=2 → iord=1 for exactly 3 cycles; WB_LW shows mem_to_reg_sel=1, reg_dst_sel=00; next fetch starts 9 cycles after the previous one.
- beq (04h): with zero=1 → pc_write=1 and pc_src_sel=1 in BRANCH; with zero=0 → pc_write=0. bne with zero=0 → pc_write=1.
- jal (03h) → one JAL cycle with pc_write=1, pc_src_sel=2, reg_wr=1, reg_dst_sel=10, mem_to_reg_sel=6.
- Exceptions:
  - addi with overflow=1 in ADDI_EX → EXC with epc_write=1, cause=1, pc_src_sel=4; reg_wr stays 0.
  - opcode 3Fh → EXC directly from DECODE with cause=0.
